// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory req/ack transaction with
// wait states and timeout, store/load alignment, and the MEM/WB register.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validE,
  input  logic [31:0] aluOutE,
  input  logic [31:0] writeDataE,
  input  logic [4:0]  writeRegAddrE,
  input  logic        regWriteE,
  input  logic        memToRegE,
  input  logic        memReadE,
  input  logic        memWriteE,
  input  logic [1:0]  memSizeE,
  input  logic        memSignedE,
  input  logic        flushM,
  output logic        stallM,
  output logic [31:0] aluOutM,
  output logic [4:0]  writeRegAddrM,
  output logic        regWriteM,
  output logic        memToRegM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        validW,
  output logic        regWriteW,
  output logic [4:0]  writeRegAddrW,
  output logic [31:0] resultW,
  output logic        excM,
  output logic [31:0] badAddrM
);

  localparam int unsigned WCNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] wdata;
  } mreg_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } wreg_t;

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  mreg_t             m_q, m_d;
  wreg_t             w_q, w_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  state_e            state;

  logic        is_mem;
  logic        misaligned;
  logic        timed_out;
  logic        req;
  logic        stall;
  logic        exc;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // State register: EX/MEM, MEM/WB and the wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      w_q    <= '0;
      wcnt_q <= '0;
    end else begin
      m_q    <= m_d;
      w_q    <= w_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Next-state: the state is a pure function of the instruction sitting in M.
  always_comb begin
    is_mem = m_q.valid & (m_q.mem_read | m_q.mem_write);
    unique case (m_q.mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = m_q.alu_out[0];
      default: misaligned = |m_q.alu_out[1:0];
    endcase
    misaligned = misaligned & is_mem;
    state      = (is_mem && !misaligned) ? ST_ACCESS : ST_PASS;
  end

  // Handshake: a transfer completes on a cycle where dmem_req and dmem_ack are
  // both high; addr/we/wdata/be hold steady until then and ack without req is ignored.
  always_comb begin
    timed_out = (state == ST_ACCESS) && (wcnt_q == WCNT_MAX);
    req       = (state == ST_ACCESS) && !timed_out;
    stall     = req && !dmem_ack;
    exc       = misaligned || timed_out;
    wcnt_d    = stall ? wcnt_q + 1'b1 : '0;
  end

  always_comb begin
    load_byte = 8'h00;
    unique case (m_q.alu_out[1:0])
      2'd0: load_byte = dmem_rdata[7:0];
      2'd1: load_byte = dmem_rdata[15:8];
      2'd2: load_byte = dmem_rdata[23:16];
      2'd3: load_byte = dmem_rdata[31:24];
    endcase
    load_half = m_q.alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (m_q.mem_size)
      2'b00:   load_data = {{24{m_q.mem_signed & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{m_q.mem_signed & load_half[15]}}, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // A flush or empty EX slot becomes a bubble; during a stall M simply holds.
  always_comb begin
    m_d = m_q;
    if (!stall) begin
      if (flushM || !validE) begin
        m_d = '0;
      end else begin
        m_d.valid      = 1'b1;
        m_d.reg_write  = regWriteE;
        m_d.mem_to_reg = memToRegE;
        m_d.mem_read   = memReadE;
        m_d.mem_write  = memWriteE;
        m_d.mem_size   = memSizeE;
        m_d.mem_signed = memSignedE;
        m_d.rd         = writeRegAddrE;
        m_d.alu_out    = aluOutE;
        m_d.wdata      = writeDataE;
      end
    end
  end

  // Faulting ops still retire into W so the slot stays in order, but never write.
  always_comb begin
    w_d = w_q;
    if (!stall) begin
      w_d.valid     = m_q.valid;
      w_d.reg_write = m_q.reg_write & ~exc;
      w_d.rd        = m_q.rd;
      w_d.result    = m_q.mem_to_reg ? load_data : m_q.alu_out;
    end
  end

  // Outputs.
  always_comb begin
    dmem_req   = req;
    dmem_we    = req & m_q.mem_write;
    dmem_addr  = req ? {m_q.alu_out[31:2], 2'b00} : 32'h0;
    dmem_wdata = 32'h0;
    dmem_be    = 4'b0000;
    if (req) begin
      unique case (m_q.mem_size)
        2'b00: begin
          dmem_wdata = {4{m_q.wdata[7:0]}};
          dmem_be    = 4'b0001 << m_q.alu_out[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{m_q.wdata[15:0]}};
          dmem_be    = 4'b0011 << {m_q.alu_out[1], 1'b0};
        end
        default: begin
          dmem_wdata = m_q.wdata;
          dmem_be    = 4'b1111;
        end
      endcase
    end
    stallM        = stall;
    excM          = exc;
    badAddrM      = exc ? m_q.alu_out : 32'h0;
    aluOutM       = m_q.alu_out;
    writeRegAddrM = m_q.rd;
    regWriteM     = m_q.reg_write;
    memToRegM     = m_q.mem_to_reg;
    validW        = w_q.valid;
    regWriteW     = w_q.reg_write;
    writeRegAddrW = w_q.rd;
    resultW       = w_q.result;
  end

endmodule
